// File: rtl/id_regfile.sv
// Decode-stage register file with write-through bypass and a per-register
// pending-write scoreboard that stalls RAW hazards and counter saturation.
module id_regfile #(
  parameter int unsigned NREG = 8,
  parameter int unsigned W    = 16
) (
  input  logic                       CLOCK_50,
  input  logic                       rst_n,
  input  logic                       wb_en,
  input  logic [$clog2(NREG)-1:0]    wb_addr,
  input  logic [W-1:0]               wb_data,
  input  logic [$clog2(NREG)-1:0]    rd_addr_a,
  input  logic [$clog2(NREG)-1:0]    rd_addr_b,
  input  logic                       use_a,
  input  logic                       use_b,
  input  logic                       issue_valid,
  input  logic                       issue_writes,
  input  logic [$clog2(NREG)-1:0]    issue_dest,
  output logic [W-1:0]               rd_data_a,
  output logic [W-1:0]               rd_data_b,
  output logic                       stall,
  output logic                       err_underflow
);

  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned CW   = 2;
  localparam logic [CW-1:0] CNT_MAX = CW'(3);

  logic [W-1:0]  regs    [NREG];
  logic [CW-1:0] cnt     [NREG];
  logic [CW-1:0] cnt_nxt [NREG];
  logic [NREG-1:0] inc_vec;
  logic [NREG-1:0] dec_vec;

  logic          wb_live;
  logic          busy_a;
  logic          busy_b;
  logic          dest_full;
  logic          accept;
  logic          underflow;
  logic [W-1:0]  rd_a_nxt;
  logic [W-1:0]  rd_b_nxt;

  assign wb_live = wb_en && (wb_addr != '0);

  // A source is busy unless its last outstanding write-back lands this cycle.
  always_comb begin
    busy_a = 1'b0;
    busy_b = 1'b0;
    if ((rd_addr_a != '0) && (cnt[rd_addr_a] != '0) &&
        !(wb_en && (wb_addr == rd_addr_a) && (cnt[rd_addr_a] == CW'(1))))
      busy_a = 1'b1;
    if ((rd_addr_b != '0) && (cnt[rd_addr_b] != '0) &&
        !(wb_en && (wb_addr == rd_addr_b) && (cnt[rd_addr_b] == CW'(1))))
      busy_b = 1'b1;
  end

  always_comb begin
    dest_full = issue_writes && (issue_dest != '0) &&
                (cnt[issue_dest] == CNT_MAX) &&
                !(wb_en && (wb_addr == issue_dest));
    stall     = issue_valid &&
                ((use_a && busy_a) || (use_b && busy_b) || dest_full);
    accept    = issue_valid && !stall && issue_writes && (issue_dest != '0);
    underflow = wb_live && (cnt[wb_addr] == '0);
  end

  // Scoreboard next state; simultaneous issue and write-back cancel out.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = accept && (issue_dest == AW'(r));
      dec_vec[r] = wb_en && (wb_addr == AW'(r)) && (cnt[r] != '0);
      cnt_nxt[r] = cnt[r];
      if (r == 0)
        cnt_nxt[r] = '0;
      else if (inc_vec[r] && !dec_vec[r])
        cnt_nxt[r] = cnt[r] + CW'(1);
      else if (dec_vec[r] && !inc_vec[r])
        cnt_nxt[r] = cnt[r] - CW'(1);
    end
  end

  // Operand select: R0, then write-through bypass, then the array.
  always_comb begin
    rd_a_nxt = regs[rd_addr_a];
    rd_b_nxt = regs[rd_addr_b];
    if (rd_addr_a == '0)
      rd_a_nxt = '0;
    else if (wb_en && (wb_addr == rd_addr_a))
      rd_a_nxt = wb_data;
    if (rd_addr_b == '0)
      rd_b_nxt = '0;
    else if (wb_en && (wb_addr == rd_addr_b))
      rd_b_nxt = wb_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      rd_data_a     <= '0;
      rd_data_b     <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
        if (r == 0)
          regs[r] <= '0;
        else if (wb_en && (wb_addr == AW'(r)))
          regs[r] <= wb_data;
      end
      rd_data_a     <= rd_a_nxt;
      rd_data_b     <= rd_b_nxt;
      err_underflow <= err_underflow || underflow;
    end
  end

endmodule

// File: tb/tb_id_regfile.sv
// Directed bench for id_regfile: bypass, RAW stall, WAW saturation,
// underflow flag and mid-operation reset.
module tb_id_regfile;

  logic        CLOCK_50;
  logic        rst_n;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic        use_a;
  logic        use_b;
  logic        issue_valid;
  logic        issue_writes;
  logic [2:0]  issue_dest;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        stall;
  logic        err_underflow;

  int checks;
  int errors;

  id_regfile #(.NREG(8), .W(16)) dut (
    .CLOCK_50     (CLOCK_50),
    .rst_n        (rst_n),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .use_a        (use_a),
    .use_b        (use_b),
    .issue_valid  (issue_valid),
    .issue_writes (issue_writes),
    .issue_dest   (issue_dest),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .stall        (stall),
    .err_underflow(err_underflow)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle();
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    use_a = 1'b0; use_b = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    issue_valid = 1'b0; issue_writes = 1'b0; issue_dest = '0;
  endtask

  task automatic offer_write(input logic [2:0] dest);
    idle();
    issue_valid = 1'b1; issue_writes = 1'b1; issue_dest = dest;
  endtask

  task automatic wb(input logic [2:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    check("rst_rd_a", 32'(rd_data_a), 32'h0);
    check("rst_rd_b", 32'(rd_data_b), 32'h0);
    check("rst_err", 32'(err_underflow), 32'h0);
    idle(); issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd1; issue_writes = 1'b1; issue_dest = 3'd1;
    #1 check("rst_stall", 32'(stall), 32'h0);
    idle();
    step();

    // Issue R3, see the RAW stall, then write back BEEF and read it.
    offer_write(3'd3);
    #1 check("iss3_stall", 32'(stall), 32'h0);
    step();
    idle(); issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd3;
    #1 check("raw3_stall", 32'(stall), 32'h1);
    step();
    idle(); wb(3'd3, 16'hBEEF);
    step();
    idle(); rd_addr_a = 3'd3; rd_addr_b = 3'd0;
    step();
    check("rd_beef", 32'(rd_data_a), 32'h0000BEEF);
    check("rd_r0", 32'(rd_data_b), 32'h0);

    // Same-cycle write-through bypass on R5.
    offer_write(3'd5);
    step();
    idle(); wb(3'd5, 16'h1234); rd_addr_a = 3'd5; rd_addr_b = 3'd3;
    step();
    check("bypass_a", 32'(rd_data_a), 32'h00001234);
    check("held_b", 32'(rd_data_b), 32'h0000BEEF);

    // RAW on R2: stalled offer, then released by the last write-back.
    offer_write(3'd2);
    #1 check("iss2_stall", 32'(stall), 32'h0);
    step();
    idle(); issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd2;
    #1 check("raw2_stall", 32'(stall), 32'h1);
    step();
    wb(3'd2, 16'h0AAA);
    #1 check("raw2_release", 32'(stall), 32'h0);
    step();
    check("raw2_bypass", 32'(rd_data_a), 32'h00000AAA);
    idle(); issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd2;
    #1 check("raw2_clear", 32'(stall), 32'h0);
    step();

    // WAW saturation on R4.
    for (int i = 0; i < 3; i++) begin
      offer_write(3'd4);
      #1 check($sformatf("waw_iss%0d", i), 32'(stall), 32'h0);
      step();
    end
    offer_write(3'd4);
    #1 check("waw_full", 32'(stall), 32'h1);
    step();
    wb(3'd4, 16'h4444);
    #1 check("waw_wb_accept", 32'(stall), 32'h0);
    step();
    offer_write(3'd4);
    #1 check("waw_still3", 32'(stall), 32'h1);
    idle(); wb(3'd4, 16'h4445);
    step();
    idle(); issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd4; wb(3'd4, 16'h4446);
    #1 check("waw_cnt2_busy", 32'(stall), 32'h1);
    step();
    #1 check("waw_cnt1_free", 32'(stall), 32'h0);
    step();
    idle(); issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd4;
    #1 check("waw_drained", 32'(stall), 32'h0);
    check("waw_no_err", 32'(err_underflow), 32'h0);
    step();

    // Own destination as source uses the pre-issue count.
    offer_write(3'd7); use_a = 1'b1; rd_addr_a = 3'd7;
    #1 check("self_src", 32'(stall), 32'h0);
    step();
    idle(); issue_valid = 1'b1; use_b = 1'b1; rd_addr_b = 3'd7;
    #1 check("self_after", 32'(stall), 32'h1);
    idle(); wb(3'd7, 16'h7777);
    step();
    check("pre_uf_err", 32'(err_underflow), 32'h0);

    // Underflow on R6: written anyway, flag sticky.
    idle(); wb(3'd6, 16'h6666);
    step();
    check("uf_set", 32'(err_underflow), 32'h1);
    idle(); rd_addr_a = 3'd6;
    step();
    check("uf_written", 32'(rd_data_a), 32'h00006666);
    step();
    step();
    check("uf_sticky", 32'(err_underflow), 32'h1);

    // Mid-operation reset with R1 count at 2 and a concurrent write-back.
    offer_write(3'd1);
    step();
    offer_write(3'd1);
    step();
    idle(); rd_addr_a = 3'd6; rd_addr_b = 3'd3; wb(3'd1, 16'h1111);
    offer_write(3'd1); wb(3'd1, 16'h1111); rd_addr_a = 3'd6; rd_addr_b = 3'd3;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mrst_rd_a", 32'(rd_data_a), 32'h0);
    check("mrst_rd_b", 32'(rd_data_b), 32'h0);
    check("mrst_err", 32'(err_underflow), 32'h0);
    idle(); issue_valid = 1'b1; use_a = 1'b1; rd_addr_a = 3'd1;
    #1 check("mrst_stall", 32'(stall), 32'h0);
    idle(); wb(3'd0, 16'hFFFF); rd_addr_a = 3'd0; rd_addr_b = 3'd3;
    step();
    check("r0_reads0", 32'(rd_data_a), 32'h0);
    check("r3_cleared", 32'(rd_data_b), 32'h0);
    check("r0_no_err", 32'(err_underflow), 32'h0);
    idle(); rd_addr_a = 3'd1;
    step();
    check("r1_cleared", 32'(rd_data_a), 32'h0);
    idle(); wb(3'd1, 16'h5A5A);
    step();
    check("flush_uf", 32'(err_underflow), 32'h1);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_regfile.md
ID_REGFILE -- requirements
Module: id_regfile

Interface
REQ-001 The block SHALL have one clock, CLOCK_50, and the reset rst_n, which is synchronous and active-low.
REQ-002 The block SHALL have parameter NREG, default 8, giving the number of architectural registers (address width 3).
REQ-003 The block SHALL have parameter W, default 16, giving the data width.
REQ-004 The block SHALL have port CLOCK_50, input, 1 bit: rising-edge clock for all state.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port wb_en, input, 1 bit: write-back strobe from the WB stage.
REQ-007 The block SHALL have port wb_addr, input, 3 bits: write-back destination register.
REQ-008 The block SHALL have port wb_data, input, 16 bits: write-back value (WB stage result).
REQ-009 The block SHALL have ports rd_addr_a and rd_addr_b, input, 3 bits each: source register addresses.
REQ-010 The block SHALL have ports use_a and use_b, input, 1 bit each: the matching source is actually consumed.
REQ-011 The block SHALL have port issue_valid, input, 1 bit: the decode stage offers an instruction.
REQ-012 The block SHALL have port issue_writes, input, 1 bit: the offered instruction writes a register.
REQ-013 The block SHALL have port issue_dest, input, 3 bits: destination of the offered instruction.
REQ-014 The block SHALL have ports rd_data_a and rd_data_b, output, 16 bits each: registered source operands.
REQ-015 The block SHALL have port stall, output, 1 bit: combinational; the offer is refused this cycle.
REQ-016 The block SHALL have port err_underflow, output, 1 bit: sticky write-back-without-issue flag.

Function
REQ-017 Register file: R0 SHALL always read 0, and writes to R0 SHALL be ignored with no error.
REQ-018 On each posedge with wb_en=1 and wb_addr!=0, reg[wb_addr] SHALL be loaded with wb_data.
REQ-019 rd_data_x SHALL be registered on every posedge, with 1-cycle latency and independent of stall.
REQ-020 rd_data_x SHALL be loaded with 0 when rd_addr_x=0.
REQ-021 rd_data_x SHALL be loaded with wb_data when wb_en=1 and wb_addr=rd_addr_x (write-through bypass).
REQ-022 Otherwise, rd_data_x SHALL be loaded with reg[rd_addr_x].
REQ-023 Scoreboard: each register r=1..7 SHALL have a 2-bit pending counter cnt[r] (0..3) of issued, not-yet-written-back writes.
REQ-024 busy(r) SHALL be (cnt[r]!=0) AND NOT (wb_en AND wb_addr=r AND cnt[r]=1), so the last outstanding write-back clears the hazard in the same cycle.
REQ-025 busy(0) SHALL be 0.
REQ-026 stall SHALL equal issue_valid AND ((use_a AND busy(rd_addr_a)) OR (use_b AND busy(rd_addr_b)) OR (issue_writes AND issue_dest!=0 AND cnt[issue_dest]=3 AND NOT (wb_en AND wb_addr=issue_dest))).
REQ-027 An issue SHALL be accepted when issue_valid=1, stall=0, issue_writes=1 and issue_dest!=0.
REQ-028 For each r, an accepted issue to r SHALL increment cnt[r].
REQ-029 For each r, a write-back to r with cnt[r]!=0 SHALL decrement cnt[r].
REQ-030 For each r, an increment and a decrement in the same cycle SHALL leave cnt[r] unchanged.
REQ-031 cnt[r] SHALL never wrap: a saturated counter (3) is protected by the stall, and 0 never decrements.
REQ-032 A write-back to r!=0 while cnt[r]=0 SHALL still write the register and SHALL set err_underflow=1 on the next edge.
REQ-033 err_underflow SHALL hold at 1 until reset.
REQ-034 A stalled offer SHALL change no state; the decode stage re-presents the same offer, and it is accepted on the first cycle stall=0.
REQ-035 A source equal to the accepted instruction's own destination SHALL be checked against the pre-issue cnt only.

Reset
REQ-036 While rst_n=0 at a posedge, all registers, all cnt[r], rd_data_a, rd_data_b and err_underflow SHALL be cleared to 0.
REQ-037 Reset SHALL take priority over a simultaneous write-back or issue.
REQ-038 Reset mid-operation SHALL discard all pending counts, and later write-backs from the flushed pipeline SHALL set err_underflow.
REQ-039 stall SHALL be 0 after reset for any offer, because all counters are 0.

Verification
REQ-040 Write-back then read: wb R3=16'hBEEF; next cycle rd_addr_a=3 -> rd_data_a=16'hBEEF one edge later; rd_addr_b=0 -> rd_data_b=0.
REQ-041 Bypass: wb_en=1, wb_addr=5, wb_data=16'h1234 and rd_addr_a=5 in the same cycle -> rd_data_a=16'h1234 after that edge.
REQ-042 RAW hazard: issue dest=2 accepted -> next cycle offer with use_a=1, rd_addr_a=2 gives stall=1; in the cycle wb_addr=2 arrives (cnt=1) -> stall=0 and issue accepted.
REQ-043 WAW saturation: three accepted issues to R4 -> fourth offer to R4 stalls (stall=1, cnt=3); the same offer with a concurrent wb to R4 -> accepted and cnt stays 3.
REQ-044 Underflow: wb to R6 with cnt[6]=0 -> R6 written, err_underflow=1 and sticky; wb to R0 -> no error and R0 reads 0.
REQ-045 Reset mid-operation: cnt[1]=2, then rst_n=0 for one edge -> all outputs 0 and offer with use_a=1, rd_addr_a=1 gives stall=0.
